// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

    // Branch-control FSM states
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } br_state_e;

    // Storage width for register addresses in the tracker.
    // Narrower register files are zero-extended into this field.
    localparam int unsigned TRK_ADDR_W = 8;

    // Forward select value meaning "take operand from regfile / ID_EX"
    localparam int unsigned FWD_SEL_NONE = 0;

    // One in-flight instruction in the scoreboard; rs fields only matter in EX
    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [TRK_ADDR_W-1:0] wr_addr;
        logic                  is_load;
        logic [TRK_ADDR_W-1:0] rs1;
        logic [TRK_ADDR_W-1:0] rs2;
        logic                  rs1_used;
        logic                  rs2_used;
    } trk_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_tracker.sv
// Per-stage scoreboard of in-flight register writers with load-use
// detection and EX-stage forward selection.
module hazard_tracker
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_rs1_used,
    input  logic                  i_id_rs2_used,
    input  logic                  i_id_wr_en,
    input  logic [REG_ADDR_W-1:0] i_id_wr_addr,
    input  logic                  i_id_is_load,
    input  logic                  i_bubble,
    output logic                  o_load_use,
    output logic [SEL_W-1:0]      o_fwd_sel_1,
    output logic [SEL_W-1:0]      o_fwd_sel_2
);

    trk_entry_t                r_trk [0:FWD_STAGES];
    trk_entry_t                w_new;
    logic [TRK_ADDR_W-1:0]     w_id_rs1;
    logic [TRK_ADDR_W-1:0]     w_id_rs2;

    assign w_id_rs1 = TRK_ADDR_W'(i_id_rs1);
    assign w_id_rs2 = TRK_ADDR_W'(i_id_rs2);

    // Entry e writes register r (r0 never matches when hardwired)
    function automatic logic f_match(input trk_entry_t e, input logic [TRK_ADDR_W-1:0] r);
        return e.valid && e.wr_en && (e.wr_addr == r) && !((ZERO_REG != 0) && (r == '0));
    endfunction

    // Build the incoming EX entry; bubbles and idle ID become all-zero entries
    always_comb begin
        w_new = '0;
        if (i_id_valid && !i_bubble) begin
            w_new.valid    = 1'b1;
            w_new.wr_en    = i_id_wr_en;
            w_new.wr_addr  = TRK_ADDR_W'(i_id_wr_addr);
            w_new.is_load  = i_id_is_load;
            w_new.rs1      = w_id_rs1;
            w_new.rs2      = w_id_rs2;
            w_new.rs1_used = i_id_rs1_used;
            w_new.rs2_used = i_id_rs2_used;
        end
    end

    // Shift register: the back end always advances, oldest entry drops off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k <= FWD_STAGES; k++) begin
                r_trk[k] <= '0;
            end
        end else begin
            for (int unsigned k = FWD_STAGES; k >= 1; k--) begin
                r_trk[k] <= r_trk[k-1];
            end
            r_trk[0] <= w_new;
        end
    end

    // Load-use: an ID source needs a load whose data is not yet forwardable
    always_comb begin
        o_load_use = 1'b0;
        for (int unsigned j = 0; j < LOAD_LAT; j++) begin
            if (r_trk[j].is_load &&
                ((i_id_rs1_used && f_match(r_trk[j], w_id_rs1)) ||
                 (i_id_rs2_used && f_match(r_trk[j], w_id_rs2)))) begin
                o_load_use = 1'b1;
            end
        end
        o_load_use = o_load_use && i_id_valid;
    end

    // Forward selects for the EX instruction; scanning oldest-first lets the
    // youngest matching producer overwrite older ones
    always_comb begin
        o_fwd_sel_1 = SEL_W'(FWD_SEL_NONE);
        o_fwd_sel_2 = SEL_W'(FWD_SEL_NONE);
        for (int unsigned k = FWD_STAGES; k >= 1; k--) begin
            if (r_trk[0].rs1_used && f_match(r_trk[k], r_trk[0].rs1)) begin
                o_fwd_sel_1 = SEL_W'(k);
            end
            if (r_trk[0].rs2_used && f_match(r_trk[k], r_trk[0].rs2)) begin
                o_fwd_sel_2 = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and branch-control unit: scoreboard, branch FSM and
// saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_wr_addr,
    input  logic                  id_is_load,
    input  logic                  id_is_branch,
    input  logic                  br_resolve_valid,
    input  logic                  br_taken,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_if_id,
    output logic [SEL_W-1:0]      fwd_sel_1,
    output logic [SEL_W-1:0]      fwd_sel_2,
    output logic                  br_busy,
    output logic [CNT_W-1:0]      stall_cnt
);

    br_state_e        r_state;
    br_state_e        w_state_nxt;
    logic             w_load_use;
    logic [CNT_W-1:0] r_stall_cnt;

    hazard_tracker #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_STAGES (FWD_STAGES),
        .LOAD_LAT   (LOAD_LAT),
        .ZERO_REG   (ZERO_REG),
        .SEL_W      (SEL_W)
    ) u_tracker (
        .clk           (clk),
        .rst_n         (reset),
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_rs1_used (id_rs1_used),
        .i_id_rs2_used (id_rs2_used),
        .i_id_wr_en    (id_wr_en),
        .i_id_wr_addr  (id_wr_addr),
        .i_id_is_load  (id_is_load),
        .i_bubble      (bubble_ex),
        .o_load_use    (w_load_use),
        .o_fwd_sel_1   (fwd_sel_1),
        .o_fwd_sel_2   (fwd_sel_2)
    );

    // Branch FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Branch FSM next state and pipeline control outputs
    always_comb begin
        w_state_nxt = r_state;
        stall_if    = w_load_use;
        stall_id    = w_load_use;
        bubble_ex   = w_load_use;
        flush_if_id = 1'b0;
        br_busy     = (r_state != RUN);
        unique case (r_state)
            RUN: begin
                if (id_valid && id_is_branch && !w_load_use) begin
                    w_state_nxt = BR_WAIT;
                end
            end
            BR_WAIT: begin
                stall_if = 1'b1;
                if (br_resolve_valid) begin
                    if (br_taken) begin
                        flush_if_id = 1'b1;
                        w_state_nxt = FLUSH;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            FLUSH: begin
                bubble_ex   = 1'b1;
                flush_if_id = 1'b1;
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Saturating count of cycles with the PC held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall_if && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl. A default instance and
// an alternate instance (ZERO_REG=0, CNT_W=4) share the same stimulus.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_rs1_used, id_rs2_used, id_wr_en, id_is_load, id_is_branch;
    logic [2:0] id_rs1, id_rs2, id_wr_addr;
    logic       br_resolve_valid, br_taken;

    logic        stall_if, stall_id, bubble_ex, flush_if_id, br_busy;
    logic [1:0]  fwd_sel_1, fwd_sel_2;
    logic [15:0] stall_cnt;

    logic        a_stall_if, a_stall_id, a_bubble_ex, a_flush_if_id, a_br_busy;
    logic [1:0]  a_fwd_sel_1, a_fwd_sel_2;
    logic [3:0]  a_stall_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .id_is_branch(id_is_branch), .br_resolve_valid(br_resolve_valid), .br_taken(br_taken),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
        .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2), .br_busy(br_busy), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(
        .ZERO_REG (0),
        .CNT_W    (4)
    ) u_dut_alt (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .id_is_branch(id_is_branch), .br_resolve_valid(br_resolve_valid), .br_taken(br_taken),
        .stall_if(a_stall_if), .stall_id(a_stall_id), .bubble_ex(a_bubble_ex), .flush_if_id(a_flush_if_id),
        .fwd_sel_1(a_fwd_sel_1), .fwd_sel_2(a_fwd_sel_2), .br_busy(a_br_busy), .stall_cnt(a_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ID instruction: valid, rs1, rs1_used, rs2, rs2_used, wr_en, wr_addr, is_load, is_branch
    task automatic drive_id(input logic v, input logic [2:0] r1, input logic u1,
                            input logic [2:0] r2, input logic u2, input logic we,
                            input logic [2:0] wa, input logic ld, input logic br);
        id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_wr_en = we; id_wr_addr = wa; id_is_load = ld; id_is_branch = br;
    endtask

    task automatic nop();
        drive_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        br_resolve_valid = 1'b0;
        br_taken = 1'b0;
        nop();
        repeat (2) cyc();
        #1;
        check("rst_stall_if", 32'(stall_if), 0);
        check("rst_bubble", 32'(bubble_ex), 0);
        check("rst_flush", 32'(flush_if_id), 0);
        check("rst_fwd", 32'({fwd_sel_1, fwd_sel_2}), 0);
        check("rst_busy", 32'(br_busy), 0);
        check("rst_cnt", 32'(stall_cnt), 0);
        reset = 1'b1;
        cyc();

        // Load r2, then consumer of r2 in rs1: one stall, then forward from stage 2
        drive_id(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        #1 check("ld_issue_stall", 32'(stall_if), 0);
        cyc();
        drive_id(1'b1, 3'd2, 1'b1, 3'd4, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        #1;
        check("lu_stall_if", 32'(stall_if), 1);
        check("lu_stall_id", 32'(stall_id), 1);
        check("lu_bubble", 32'(bubble_ex), 1);
        check("lu_cnt_before", 32'(stall_cnt), 0);
        cyc();
        #1;
        check("lu_released", 32'({stall_if, stall_id, bubble_ex}), 0);
        check("lu_cnt_after", 32'(stall_cnt), 1);
        cyc();
        nop();
        #1 check("lu_fwd_sel_1", 32'(fwd_sel_1), 2);
        repeat (3) cyc();

        // ADD writes r3; next instruction reads r3 as rs2
        drive_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        cyc();
        drive_id(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
        #1 check("add_no_stall", 32'(stall_if), 0);
        cyc();
        nop();
        #1;
        check("add_fwd_sel_2", 32'(fwd_sel_2), 1);
        check("add_fwd_sel_1", 32'(fwd_sel_1), 0);
        repeat (3) cyc();

        // Two writers of r3 back to back, then consumer: youngest wins
        drive_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        cyc();
        drive_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        cyc();
        drive_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        nop();
        #1 check("youngest_fwd", 32'(fwd_sel_1), 1);
        repeat (3) cyc();

        // Writer of r0 then consumer of r0: hardwired r0 never forwards
        drive_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        cyc();
        drive_id(1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        #1 check("r0_no_stall", 32'(stall_if), 0);
        cyc();
        nop();
        #1;
        check("r0_fwd_zreg1", 32'(fwd_sel_1), 0);
        check("r0_fwd_zreg0", 32'(a_fwd_sel_1), 1);
        repeat (3) cyc();

        // Taken branch resolved two cycles after issue
        drive_id(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        #1 check("br_issue_busy", 32'(br_busy), 0);
        cyc();
        nop();
        #1;
        check("brw_stall_if", 32'(stall_if), 1);
        check("brw_busy", 32'(br_busy), 1);
        check("brw_no_flush", 32'(flush_if_id), 0);
        cyc();
        br_resolve_valid = 1'b1;
        br_taken = 1'b1;
        #1;
        check("brt_flush_resolve", 32'(flush_if_id), 1);
        check("brt_stall_resolve", 32'(stall_if), 1);
        cyc();
        br_resolve_valid = 1'b0;
        br_taken = 1'b0;
        #1;
        check("flush_state_flush", 32'(flush_if_id), 1);
        check("flush_state_bubble", 32'(bubble_ex), 1);
        check("flush_state_stall", 32'(stall_if), 0);
        check("flush_state_busy", 32'(br_busy), 1);
        cyc();
        #1;
        check("post_flush_busy", 32'(br_busy), 0);
        check("post_flush_flush", 32'(flush_if_id), 0);
        check("br_taken_cnt", 32'(stall_cnt), 3);

        // Not-taken branch
        drive_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        cyc();
        nop();
        cyc();
        br_resolve_valid = 1'b1;
        br_taken = 1'b0;
        #1 check("brnt_no_flush", 32'(flush_if_id), 0);
        cyc();
        br_resolve_valid = 1'b0;
        #1;
        check("brnt_busy", 32'(br_busy), 0);
        check("brnt_bubble", 32'(bubble_ex), 0);
        check("brnt_cnt", 32'(stall_cnt), 5);

        // Resolve while in RUN is ignored
        br_resolve_valid = 1'b1;
        br_taken = 1'b1;
        #1 check("run_resolve_flush", 32'(flush_if_id), 0);
        cyc();
        br_resolve_valid = 1'b0;
        br_taken = 1'b0;
        #1 check("run_resolve_busy", 32'(br_busy), 0);

        // Park in BR_WAIT long enough to saturate the 4-bit counter
        drive_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        cyc();
        nop();
        for (int i = 0; i < 21; i++) cyc();
        #1;
        check("sat_cnt_w4", 32'(a_stall_cnt), 15);
        check("cnt_w16", 32'(stall_cnt), 26);

        // Load into the tracker while still in BR_WAIT, then a dependent op
        drive_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        cyc();
        drive_id(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
        #1;
        check("lu_brw_stall_id", 32'(stall_id), 1);
        check("lu_brw_bubble", 32'(bubble_ex), 1);
        check("lu_brw_busy", 32'(br_busy), 1);

        // Asynchronous reset mid-branch with no clock edge
        reset = 1'b0;
        #1;
        check("arst_stall", 32'({stall_if, stall_id, bubble_ex}), 0);
        check("arst_flush_busy", 32'({flush_if_id, br_busy}), 0);
        check("arst_fwd", 32'({fwd_sel_1, fwd_sel_2}), 0);
        check("arst_cnt", 32'(stall_cnt), 0);
        reset = 1'b1;
        #1 check("rel_no_stall", 32'(stall_if), 0);
        cyc();
        nop();
        #1;
        check("rel_busy", 32'(br_busy), 0);
        check("rel_stall", 32'(stall_if), 0);
        check("rel_cnt", 32'(stall_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
